scaler_channel_reader: RTL

- Host-side reader for the timer/scaler module's channel-read interface.
- Drives the active-low read strobes RCHAT_ and RCHBT_, and samples the 14-bit CHAT and CHBT buses. CHAT is the high word; CHBT is the low word.
- Assembles a coherent 28-bit scaler snapshot. Uses a read-A / read-B / re-read-A sequence so a carry between the two reads is detected and the read retried.
- Sits between the scaler module and any consumer needing timestamps (downlink, test sequencer).

---
 rtl/scaler_read_pkg.sv | 21 ++
 rtl/scaler_strobe_timer.sv | 25 ++
 rtl/scaler_channel_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/scaler_read_pkg.sv
// Shared widths, retry-counter sizing and FSM state encoding for the scaler channel reader.
package scaler_read_pkg;

    localparam int WORD_W          = 14;
    localparam int COUNT_W         = 2 * WORD_W;
    localparam int MAX_RETRY_LIMIT = 7;
    localparam int RETRY_W         = $clog2(MAX_RETRY_LIMIT + 1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RDA1  = 4'd1,
        ST_GAPA1 = 4'd2,
        ST_RDB   = 4'd3,
        ST_GAPB  = 4'd4,
        ST_RDA2  = 4'd5,
        ST_GAPA2 = 4'd6,
        ST_CHECK = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

endpackage

// File: rtl/scaler_strobe_timer.sv
// Settle-time down-counter shared by every read phase; o_sample marks the last strobe-low cycle.
module scaler_strobe_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_sample
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= 4'(SETTLE_CYCLES);
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_sample = (r_cnt == 4'd1);

endmodule

// File: rtl/scaler_channel_reader.sv
// Coherent 28-bit snapshot reader: read A, read B, re-read A, retry on a high-word carry.
// Optional macro SCALER_READ_DELTA_EN adds the delta port and the prev-snapshot register.
module scaler_channel_reader
    import scaler_read_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic               CLOCK,
    input  logic               rst_,
    input  logic               req,
    output logic               busy,
    output logic               RCHAT_,
    output logic               RCHBT_,
    input  logic [WORD_W-1:0]  CHAT,
    input  logic [WORD_W-1:0]  CHBT,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    input  logic               count_ready,
    output logic               count_err,
    output state_e             o_dbg_state
`ifdef SCALER_READ_DELTA_EN
    ,
    output logic [COUNT_W-1:0] delta
`endif
);

    // Result handshake: count_valid stays high with count/count_err frozen until the
    // edge where count_valid & count_ready are both high; ready alone does nothing.
    state_e               r_state;
    state_e               w_state_next;
    logic                 w_load;
    logic                 w_sample;
    logic                 w_mismatch;
    logic                 w_retry;
    logic [RETRY_W-1:0]   r_retry;
    logic [WORD_W-1:0]    r_a1;
    logic [WORD_W-1:0]    r_a2;
    logic [WORD_W-1:0]    r_b;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_err;
    logic [COUNT_W-1:0]   w_snapshot;
`ifdef SCALER_READ_DELTA_EN
    logic [COUNT_W-1:0]   r_prev;
    logic [COUNT_W-1:0]   r_delta;
`endif

    assign w_mismatch = (r_a1 != r_a2);
    assign w_retry    = w_mismatch && (r_retry < RETRY_W'(MAX_RETRY));
    assign w_snapshot = {r_a2, r_b};

    scaler_strobe_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .i_clk    (CLOCK),
        .i_rst_n  (rst_),
        .i_load   (w_load),
        .o_sample (w_sample)
    );

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (req) w_state_next = ST_RDA1;
            ST_RDA1:  if (w_sample) w_state_next = ST_GAPA1;
            ST_GAPA1: w_state_next = ST_RDB;
            ST_RDB:   if (w_sample) w_state_next = ST_GAPB;
            ST_GAPB:  w_state_next = ST_RDA2;
            // On a retry pass the CHECK cycle itself is the high gap after A2.
            ST_RDA2:  if (w_sample) w_state_next = (r_retry == '0) ? ST_GAPA2 : ST_CHECK;
            ST_GAPA2: w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = w_retry ? ST_RDB : ST_DONE;
            ST_DONE:  if (count_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        w_load = (w_state_next != r_state) &&
                 ((w_state_next == ST_RDA1) || (w_state_next == ST_RDB) ||
                  (w_state_next == ST_RDA2));
    end

    always_comb begin
        RCHAT_      = !((r_state == ST_RDA1) || (r_state == ST_RDA2));
        RCHBT_      = (r_state != ST_RDB);
        busy        = (r_state != ST_IDLE);
        count_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_retry <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_b     <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
`ifdef SCALER_READ_DELTA_EN
            r_prev  <= '0;
            r_delta <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE:  if (req) r_retry <= '0;
                ST_RDA1:  if (w_sample) r_a1 <= CHAT;
                ST_RDB:   if (w_sample) r_b <= CHBT;
                ST_RDA2:  if (w_sample) r_a2 <= CHAT;
                ST_CHECK: begin
                    if (w_retry) begin
                        r_a1    <= r_a2;
                        r_retry <= r_retry + RETRY_W'(1);
                    end else begin
                        r_count <= w_snapshot;
                        r_err   <= w_mismatch;
`ifdef SCALER_READ_DELTA_EN
                        r_delta <= w_snapshot - r_prev;
                        r_prev  <= w_snapshot;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign count       = r_count;
    assign count_err   = r_err;
    assign o_dbg_state = r_state;
`ifdef SCALER_READ_DELTA_EN
    assign delta       = r_delta;
`endif

endmodule
